// File: rtl/vend_pkg.sv
// Shared types and constants for the change payout unit.
// Holds the FSM state enum, coin values in quarter units and the amount width.
package vend_pkg;

  localparam int AMT_W = 3;

  localparam logic [AMT_W-1:0] QTR_U  = 3'd1;
  localparam logic [AMT_W-1:0] HALF_U = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_e;

endpackage

// File: rtl/payout_timer.sv
// Loadable down-counter shared by the coin pulse and inter-coin gap phases.
// Ports: clk_i, rst_ni, load_i/load_val_i (preset), expired_o (count is 0).
module payout_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/change_payout.sv
// Coin changer: pays a quarter-unit amount greedily with half dollars, then
// quarters, as timed eject pulses. Ports: CLK, RES (async low), request
// handshake, refills, clear_fault, coin drives, status, inventories.
module change_payout
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INV_W        = 8,
  parameter int INIT_INV     = 10
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  input  logic             refill_half,
  input  logic             refill_qtr,
  input  logic             clear_fault,
  output logic             halfDollar_out,
  output logic             quarter_out,
  output logic             busy,
  output logic             done,
  output logic             short_flag,
  output logic [AMT_W-1:0] short_amt,
  output logic [INV_W-1:0] half_inv,
  output logic [INV_W-1:0] qtr_inv
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [TW-1:0]    PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [INV_W-1:0] INV_MAX  = '1;
  localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);
  localparam logic [INV_W-1:0] INV_RST  = INV_W'(INIT_INV);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic             sel_half_q, sel_half_d;
  logic [INV_W-1:0] half_inv_q, half_inv_d;
  logic [INV_W-1:0] qtr_inv_q, qtr_inv_d;
  logic             half_out_q, half_out_d;
  logic             qtr_out_q, qtr_out_d;

  logic          half_dec, qtr_dec;
  logic          tmr_load, tmr_exp;
  logic [TW-1:0] tmr_val;

  payout_timer #(.CNT_W(TW)) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RES),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    sel_half_d = sel_half_q;
    half_dec   = 1'b0;
    qtr_dec    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = PULSE_LD;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          remain_d = req_amt;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remain_q >= HALF_U && half_inv_q != '0) begin
          remain_d   = remain_q - HALF_U;
          half_dec   = 1'b1;
          sel_half_d = 1'b1;
          tmr_load   = 1'b1;
          state_d    = S_PULSE;
        end else if (remain_q >= QTR_U && qtr_inv_q != '0) begin
          remain_d   = remain_q - QTR_U;
          qtr_dec    = 1'b1;
          sel_half_d = 1'b0;
          tmr_load   = 1'b1;
          state_d    = S_PULSE;
        end else if (remain_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_PULSE: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_exp) state_d = S_SELECT;
      end
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (clear_fault) begin
          remain_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A refill landing on the same edge as a dispense cancels out.
  always_comb begin
    half_inv_d = half_inv_q;
    if (refill_half && !half_dec) begin
      if (half_inv_q != INV_MAX) half_inv_d = half_inv_q + INV_ONE;
    end else if (half_dec && !refill_half) begin
      half_inv_d = half_inv_q - INV_ONE;
    end
    qtr_inv_d = qtr_inv_q;
    if (refill_qtr && !qtr_dec) begin
      if (qtr_inv_q != INV_MAX) qtr_inv_d = qtr_inv_q + INV_ONE;
    end else if (qtr_dec && !refill_qtr) begin
      qtr_inv_d = qtr_inv_q - INV_ONE;
    end
  end

  // Coin drives come from flops so they are glitch-free.
  assign half_out_d = (state_d == S_PULSE) && sel_half_d;
  assign qtr_out_d  = (state_d == S_PULSE) && !sel_half_d;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= S_IDLE;
      remain_q   <= '0;
      sel_half_q <= 1'b0;
      half_inv_q <= INV_RST;
      qtr_inv_q  <= INV_RST;
      half_out_q <= 1'b0;
      qtr_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      sel_half_q <= sel_half_d;
      half_inv_q <= half_inv_d;
      qtr_inv_q  <= qtr_inv_d;
      half_out_q <= half_out_d;
      qtr_out_q  <= qtr_out_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign short_flag     = (state_q == S_FAULT);
  assign short_amt      = short_flag ? remain_q : '0;
  assign halfDollar_out = half_out_q;
  assign quarter_out    = qtr_out_q;
  assign half_inv       = half_inv_q;
  assign qtr_inv        = qtr_inv_q;

endmodule

// File: tb/tb_change_payout.sv
// Self-checking bench for change_payout.
// Reference model: greedy coin split plus pulse/gap timing formula.
module tb_change_payout;

  localparam int P    = 4;
  localparam int G    = 2;
  localparam int W    = 8;
  localparam int INIT = 10;
  localparam int MAXI = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         RES = 1'b0;
  logic         req_valid = 1'b0;
  logic [2:0]   req_amt = 3'd0;
  logic         refill_half = 1'b0;
  logic         refill_qtr = 1'b0;
  logic         clear_fault = 1'b0;
  logic         req_ready, halfDollar_out, quarter_out;
  logic         busy, done, short_flag;
  logic [2:0]   short_amt;
  logic [W-1:0] half_inv, qtr_inv;

  int checks = 0;
  int errors = 0;
  int m_half = INIT;
  int m_qtr  = INIT;

  always #5 CLK = ~CLK;

  change_payout #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .INV_W       (W),
    .INIT_INV    (INIT)
  ) dut (
    .CLK           (CLK),
    .RES           (RES),
    .req_valid     (req_valid),
    .req_amt       (req_amt),
    .req_ready     (req_ready),
    .refill_half   (refill_half),
    .refill_qtr    (refill_qtr),
    .clear_fault   (clear_fault),
    .halfDollar_out(halfDollar_out),
    .quarter_out   (quarter_out),
    .busy          (busy),
    .done          (done),
    .short_flag    (short_flag),
    .short_amt     (short_amt),
    .half_inv      (half_inv),
    .qtr_inv       (qtr_inv)
  );

  task automatic test_reset();
    RES = 1'b0;
    #12;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        halfDollar_out !== 1'b0 || quarter_out !== 1'b0 ||
        short_flag !== 1'b0 || short_amt !== 3'd0 ||
        half_inv !== W'(INIT) || qtr_inv !== W'(INIT)) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b h=%b q=%b sf=%b sa=%0d hi=%0d qi=%0d want 1,0,0,0,0,0,0,%0d,%0d",
               req_ready, busy, done, halfDollar_out, quarter_out,
               short_flag, short_amt, half_inv, qtr_inv, INIT, INIT);
    end
    @(negedge CLK);
    RES = 1'b1;
    m_half = INIT;
    m_qtr  = INIT;
  endtask

  task automatic do_refill(input int n, input bit rnd,
                           input bit h, input bit q);
    for (int i = 0; i < n; i++) begin
      bit bh;
      bit bq;
      @(negedge CLK);
      bh = rnd ? 1'($urandom_range(0, 1)) : h;
      bq = rnd ? 1'($urandom_range(0, 1)) : q;
      refill_half = bh;
      refill_qtr  = bq;
      if (bh && m_half < MAXI) m_half++;
      if (bq && m_qtr < MAXI) m_qtr++;
    end
    @(negedge CLK);
    refill_half = 1'b0;
    refill_qtr  = 1'b0;
    checks++;
    if (half_inv !== W'(m_half) || qtr_inv !== W'(m_qtr)) begin
      errors++;
      $display("FAIL refill_inv: half=%0d qtr=%0d want %0d %0d",
               half_inv, qtr_inv, m_half, m_qtr);
    end
  endtask

  // One full request; expectations come from a greedy split and the
  // coin period of PULSE + GAP + one select cycle.
  task automatic run_req(input int amt, input bit noise);
    int nh, nq, rem, sh, n, per, endc, k, bad;
    bit got_done, got_short, tmo;
    logic [2:0] tr[$];
    logic [2:0] ex, bad_got, bad_ex;
    nh = amt / 2;
    if (nh > m_half) nh = m_half;
    rem = amt - 2 * nh;
    nq = rem;
    if (nq > m_qtr) nq = m_qtr;
    sh   = rem - nq;
    n    = nh + nq;
    per  = P + G + 1;
    endc = 2 + n * per;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: rdy=%b busy=%b want 1 0",
               req_ready, busy);
    end
    req_valid = 1'b1;
    req_amt   = 3'(amt);
    @(negedge CLK);
    req_valid = 1'b0;
    k = 1;
    got_done = 1'b0;
    got_short = 1'b0;
    tmo = 1'b0;
    forever begin
      tr.push_back({busy, halfDollar_out, quarter_out});
      if (done === 1'b1) begin got_done = 1'b1; break; end
      if (short_flag === 1'b1) begin got_short = 1'b1; break; end
      if (k >= 300) begin tmo = 1'b1; break; end
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_amt   = 3'($urandom_range(0, 7));
      end
      @(negedge CLK);
      k++;
    end
    req_valid = 1'b0;
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL req_timeout: amt=%0d no done/short in %0d cycles",
               amt, k);
      return;
    end
    checks++;
    if (k != endc || got_short != (sh != 0)) begin
      errors++;
      $display("FAIL end_cycle: amt=%0d at N+%0d short=%b want N+%0d short=%b",
               amt, k, got_short, endc, (sh != 0));
    end
    bad = -1;
    bad_got = 3'b000;
    bad_ex = 3'b000;
    for (int i = 0; i < tr.size(); i++) begin
      int idx;
      idx = i - 1;
      ex = 3'b100;
      if (idx >= 0 && idx / per < n && idx % per < P)
        ex = (idx / per < nh) ? 3'b110 : 3'b101;
      if (tr[i] !== ex && bad < 0) begin
        bad = i + 1;
        bad_got = tr[i];
        bad_ex = ex;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL pulse_trace: amt=%0d cycle N+%0d busy/half/qtr=%b want %b",
               amt, bad, bad_got, bad_ex);
    end
    m_half -= nh;
    m_qtr  -= nq;
    checks++;
    if (half_inv !== W'(m_half) || qtr_inv !== W'(m_qtr)) begin
      errors++;
      $display("FAIL req_inv: amt=%0d half=%0d qtr=%0d want %0d %0d",
               amt, half_inv, qtr_inv, m_half, m_qtr);
    end
    if (got_done) begin
      @(negedge CLK);
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_once: done=%b rdy=%b busy=%b want 0 1 0",
                 done, req_ready, busy);
      end
    end else begin
      checks++;
      if (short_amt !== 3'(sh) || done !== 1'b0) begin
        errors++;
        $display("FAIL short_amt: got %0d done=%b want %0d done=0",
                 short_amt, done, sh);
      end
      @(negedge CLK);
      refill_qtr = 1'b1;
      if (m_qtr < MAXI) m_qtr++;
      @(negedge CLK);
      refill_qtr = 1'b0;
      @(negedge CLK);
      checks++;
      if (short_flag !== 1'b1 || short_amt !== 3'(sh) ||
          req_ready !== 1'b0 || qtr_inv !== W'(m_qtr) ||
          quarter_out !== 1'b0) begin
        errors++;
        $display("FAIL fault_hold: sf=%b sa=%0d rdy=%b qi=%0d q=%b want 1 %0d 0 %0d 0",
                 short_flag, short_amt, req_ready, qtr_inv,
                 quarter_out, sh, m_qtr);
      end
      clear_fault = 1'b1;
      @(negedge CLK);
      clear_fault = 1'b0;
      checks++;
      if (short_flag !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL fault_clear: sf=%b rdy=%b want 0 1",
                 short_flag, req_ready);
      end
    end
  endtask

  task automatic test_half_only();
    run_req(6, 1'b0);
    checks++;
    if (half_inv !== W'(7) || qtr_inv !== W'(10)) begin
      errors++;
      $display("FAIL half_only_inv: half=%0d qtr=%0d want 7 10",
               half_inv, qtr_inv);
    end
  endtask

  task automatic test_quarter_only();
    run_req(6, 1'b1);
    run_req(6, 1'b1);
    run_req(2, 1'b1);
    checks++;
    if (half_inv !== W'(0)) begin
      errors++;
      $display("FAIL drain_half: half=%0d want 0", half_inv);
    end
    run_req(7, 1'b0);
    checks++;
    if (qtr_inv !== W'(3)) begin
      errors++;
      $display("FAIL quarter_only_inv: qtr=%0d want 3", qtr_inv);
    end
  endtask

  task automatic test_fault();
    run_req(2, 1'b0);
    do_refill(1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (half_inv !== W'(1) || qtr_inv !== W'(1)) begin
      errors++;
      $display("FAIL fault_setup: half=%0d qtr=%0d want 1 1",
               half_inv, qtr_inv);
    end
    run_req(5, 1'b0);
  endtask

  task automatic test_zero();
    run_req(0, 1'b1);
  endtask

  task automatic test_reset_mid_pulse();
    int rises, k, bad;
    logic prev;
    test_reset();
    @(negedge CLK);
    req_valid = 1'b1;
    req_amt   = 3'd4;
    @(negedge CLK);
    req_valid = 1'b0;
    rises = 0;
    prev = 1'b0;
    k = 0;
    while (rises < 2 && k < 40) begin
      if (halfDollar_out === 1'b1 && prev === 1'b0) rises++;
      prev = halfDollar_out;
      if (rises < 2) begin
        @(negedge CLK);
        k++;
      end
    end
    checks++;
    if (rises < 2) begin
      errors++;
      $display("FAIL mid_pulse_wait: saw %0d half pulses want 2", rises);
    end
    @(negedge CLK);
    #2 RES = 1'b0;
    #1;
    checks++;
    if (halfDollar_out !== 1'b0 || quarter_out !== 1'b0 ||
        req_ready !== 1'b1 || busy !== 1'b0 ||
        half_inv !== W'(INIT) || qtr_inv !== W'(INIT)) begin
      errors++;
      $display("FAIL reset_mid_pulse: h=%b q=%b rdy=%b busy=%b hi=%0d qi=%0d",
               halfDollar_out, quarter_out, req_ready, busy,
               half_inv, qtr_inv);
    end
    @(negedge CLK);
    RES = 1'b1;
    m_half = INIT;
    m_qtr  = INIT;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (halfDollar_out !== 1'b0 || quarter_out !== 1'b0 ||
          req_ready !== 1'b1 || half_inv !== W'(INIT))
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_resume: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      do_refill($urandom_range(0, 5), 1'b1, 1'b0, 1'b0);
      run_req($urandom_range(0, 7), 1'b1);
    end
  endtask

  // Refill on the very edge that dispenses the same coin type.
  task automatic coincident(input int amt);
    bit is_half;
    int k;
    is_half = (amt >= 2 && m_half > 0);
    @(negedge CLK);
    req_valid = 1'b1;
    req_amt   = 3'(amt);
    @(negedge CLK);
    req_valid   = 1'b0;
    refill_half = 1'b1;
    refill_qtr  = 1'b1;
    if (is_half) begin
      if (m_qtr < MAXI) m_qtr++;
    end else begin
      if (m_half < MAXI) m_half++;
    end
    @(negedge CLK);
    refill_half = 1'b0;
    refill_qtr  = 1'b0;
    checks++;
    if (half_inv !== W'(m_half) || qtr_inv !== W'(m_qtr) ||
        halfDollar_out !== is_half || quarter_out !== !is_half) begin
      errors++;
      $display("FAIL coincident: amt=%0d hi=%0d qi=%0d h=%b q=%b want %0d %0d %b %b",
               amt, half_inv, qtr_inv, halfDollar_out, quarter_out,
               m_half, m_qtr, is_half, !is_half);
    end
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL coincident_done: no done within 60 cycles");
    end
    @(negedge CLK);
  endtask

  task automatic test_refill_sat();
    int n;
    n = 254 - m_qtr;
    if (n < 0) n = 0;
    do_refill(n, 1'b0, 1'b0, 1'b1);
    checks++;
    if (qtr_inv !== W'(254)) begin
      errors++;
      $display("FAIL qtr_254: got %0d want 254", qtr_inv);
    end
    do_refill(3, 1'b0, 1'b0, 1'b1);
    checks++;
    if (qtr_inv !== W'(255)) begin
      errors++;
      $display("FAIL qtr_sat: got %0d want 255", qtr_inv);
    end
    coincident(1);
    if (m_half == 0) do_refill(1, 1'b0, 1'b1, 1'b0);
    coincident(2);
  endtask

  initial begin
    test_reset();
    test_half_only();
    test_quarter_only();
    test_fault();
    test_zero();
    test_reset_mid_pulse();
    test_random();
    test_refill_sat();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
